wr_port_arbiter: RTL
====================

# wr_port_arbiter

Round-robin arbiter that shares a single write port among four requesters, addressed by a little-endian lane range [-12:-9]. Each requester asks for a burst of 1–4 beats. The arbiter grants one lane at a time, steers that lane's data onto the shared write port for the burst, then inserts one idle gap cycle. It sits between the per-lane producers and the shared write-clocked state register in the same hierarchy, and is lint-clean with `LITENDIAN` disabled.

## Interface
- `LO`, default -12, lowest lane index, which is also the leftmost bit of every lane vector.
- `HI`, default -9, highest lane index. `HI-LO+1` must equal 4.
- `DW`, default 8, data width per lane.
- `i_clk`  in  1  single clock, all state updates on posedge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_req`  in  [LO:HI]  per-lane burst request, level-sensitive.
- `i_len`  in  [LO:HI][1:0]  per-lane burst length minus one.
- `i_data`  in  [LO:HI][DW-1:0]  per-lane write data.
- `o_gnt`  out  [LO:HI]  one-hot grant, registered.
- `o_wr_en`  out  1  shared write-port enable, registered.
- `o_wr_data`  out  DW  shared write data, which is `i_data[owner]` when `o_wr_en` is high and 0 otherwise.
- `o_owner`  out  2  owner offset, equal to lane minus `LO`; 0 when idle.
- `o_busy`  out  1  high in the BURST and GAP states.

## Operation
- Reset values: state IDLE, `o_gnt`=0, `o_wr_en`=0, `o_owner`=0, `o_busy`=0, beat counter 0, round-robin pointer = lane `LO`.
- The FSM has three states, encoded IDLE=2'b00, BURST=2'b01, GAP=2'b10. The value 2'b11 is illegal and must recover to IDLE on the next edge.
- IDLE:
  - If any `i_req` bit is set, pick the winner by searching upward from the pointer lane and wrapping from `HI` to `LO`.
  - Latch the winner's `i_len` into `len_q`, set `o_gnt` one-hot, set `o_wr_en`=1, clear the beat counter, and go to BURST.
  - If no request is set, hold.
- BURST:
  - One beat is transferred per cycle.
  - When the counter equals `len_q`, or the owner's `i_req` is low, go to GAP.
  - On that transition clear `o_gnt` and `o_wr_en`, and set the pointer to owner+1, wrapping `HI` to `LO`.
  - If the owner drops `i_req`, the abort takes effect on the same edge. The beat during which `i_req` is low is not written: `o_wr_en` is combinationally masked by the owner's `i_req`.
  - Otherwise increment the counter.
- GAP: lasts exactly one cycle, then goes to IDLE. Requests arriving in this cycle are not sampled.
- Pointer semantics: the lane just served gets the lowest priority in the next arbitration.
- Width rules:
  - The counter is 2 bits and cannot wrap, because `len_q` is at most 3.
  - `o_owner` is computed as lane − `LO` on an 8-bit signed value, then truncated to 2 bits.
- `i_len` changes after the grant are ignored.
- `i_data` is not registered. The combinational path runs `i_data` → `o_wr_data` and is gated by state.

## Timing
- Request-to-grant latency: 1 cycle. A request sampled at edge n gives `o_gnt`/`o_wr_en` high after edge n.
- A burst of `L`=len+1 beats holds `o_wr_en` for `L` cycles, followed by 1 GAP cycle.
- Minimum spacing between two grants is therefore `L`+2 edges.
- Asynchronous reset asserted mid-burst clears all outputs immediately, without waiting for a clock edge. The first arbitration after reset release restarts from lane `LO`.
- A request seen together with reset release is sampled at the first clock edge at which `i_rst_n` is high.

## Structure
- Package `wr_arb_pkg` holds:
  - `typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP} wr_arb_state_t`
  - `localparam int NLANES = 4`
  - the function that converts lane offset to one-hot.
- Sub-module `rr_pick`: purely combinational. Inputs are the request vector and the pointer offset; outputs are a valid flag and the winner offset. `wr_port_arbiter` instantiates it once.
- All lane vectors keep the [LO:HI] little-endian declaration end to end. No reversal at the sub-module boundary.

## Test plan
- Reset, then `i_req`=4'b0000 for 10 cycles → `o_busy`=0, `o_gnt`=0, `o_wr_data`=0 throughout.
- Only lane -10 requesting, with `i_len`=2 and `i_data`=8'hA5 → `o_gnt[-10]` high for 3 cycles and `o_wr_data`=8'hA5 for 3 cycles; `o_owner`=2; then 1 GAP cycle; then re-grant if the request is still held.
- All four lanes requesting with `i_len`=0 → grant order -12, -11, -10, -9, -12, with grants 3 cycles apart.
- Lane -11 is granted with `i_len`=3 and drops `i_req` on its 2nd beat → 1 write beat only, GAP on the next cycle, then the pointer moves to -10.
- `i_rst_n` pulsed low for half a cycle during the 2nd beat of a 4-beat burst → `o_wr_en`/`o_gnt` go to 0 asynchronously; after release the first grant goes to -12 if that lane is requesting.
- State register forced to 2'b11 by a bench hook → IDLE on the next edge, with `o_wr_en`=0.

Source files
------------

// File: rtl/wr_arb_pkg.sv
// Shared types and helpers for the four-lane write-port arbiter.
// Lane offset 0 is always lane LO, the leftmost bit of every lane vector.
package wr_arb_pkg;

  localparam int NLANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BURST = 2'b01,
    ST_GAP   = 2'b10
  } wr_arb_state_t;

  // Ascending range so offset 0 lands on the leftmost bit (lane LO) when
  // assigned to a [LO:HI] vector, with no reversal.
  function automatic logic [0:NLANES-1] lane_onehot(input logic [1:0] off);
    logic [0:NLANES-1] oh;
    oh      = '0;
    oh[off] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requesting lane at or above the
// pointer offset, wrapping from HI back to LO.
module rr_pick
  import wr_arb_pkg::*;
#(
  parameter int LO = -12,
  parameter int HI = -9
) (
  input  logic [LO:HI] req_i,
  input  logic [1:0]   ptr_i,
  output logic         valid_o,
  output logic [1:0]   win_o
);

  logic [NLANES-1:0] req_n;

  for (genvar k = 0; k < NLANES; k++) begin : g_norm
    assign req_n[k] = req_i[LO+k];
  end

  // NOTE: every output gets a default before the search, so no path through
  // this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    valid_o = 1'b0;
    win_o   = ptr_i;
    for (int i = NLANES - 1; i >= 0; i--) begin
      if (req_n[ptr_i + 2'(i)]) begin
        valid_o = 1'b1;
        win_o   = ptr_i + 2'(i);
      end
    end
  end

endmodule

// File: rtl/wr_port_arbiter.sv
// Shares one write port among four lanes [LO:HI]: round-robin grant, a burst
// of len+1 beats from the owner, then one idle gap cycle.
module wr_port_arbiter
  import wr_arb_pkg::*;
#(
  parameter int LO = -12,
  parameter int HI = -9,
  parameter int DW = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [LO:HI]         i_req,
  input  logic [LO:HI][1:0]    i_len,
  input  logic [LO:HI][DW-1:0] i_data,
  output logic [LO:HI]         o_gnt,
  output logic                 o_wr_en,
  output logic [DW-1:0]        o_wr_data,
  output logic [1:0]           o_owner,
  output logic                 o_busy
);

  localparam logic signed [7:0] LO_S = 8'(LO);

  logic [NLANES-1:0]         req_n;
  logic [NLANES-1:0][1:0]    len_n;
  logic [NLANES-1:0][DW-1:0] data_n;

  for (genvar k = 0; k < NLANES; k++) begin : g_norm
    assign req_n[k]  = i_req[LO+k];
    assign len_n[k]  = i_len[LO+k];
    assign data_n[k] = i_data[LO+k];
  end

  wr_arb_state_t state_q;
  logic [LO:HI]  gnt_q;
  logic          wr_en_q;
  logic [1:0]    owner_q;
  logic [1:0]    len_q;
  logic [1:0]    cnt_q;
  logic [1:0]    ptr_q;

  logic              pick_valid;
  logic [1:0]        pick_win;
  logic signed [7:0] win_lane;
  logic [1:0]        owner_d;
  logic              burst_end;

  rr_pick #(
    .LO(LO),
    .HI(HI)
  ) u_pick (
    .req_i  (i_req),
    .ptr_i  (ptr_q),
    .valid_o(pick_valid),
    .win_o  (pick_win)
  );

  // Owner is the winning lane number re-based to LO, kept as a 2-bit offset.
  assign win_lane  = LO_S + $signed({6'd0, pick_win});
  assign owner_d   = 2'(win_lane - LO_S);
  assign burst_end = (cnt_q == len_q) || !req_n[owner_q];

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      wr_en_q <= 1'b0;
      owner_q <= 2'd0;
      len_q   <= 2'd0;
      cnt_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_BURST;
            gnt_q   <= lane_onehot(pick_win);
            wr_en_q <= 1'b1;
            owner_q <= owner_d;
            len_q   <= len_n[pick_win];
            cnt_q   <= 2'd0;
          end
        end
        ST_BURST: begin
          if (burst_end) begin
            state_q <= ST_GAP;
            gnt_q   <= '0;
            wr_en_q <= 1'b0;
            owner_q <= 2'd0;
            ptr_q   <= owner_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          wr_en_q <= 1'b0;
          owner_q <= 2'd0;
          cnt_q   <= 2'd0;
        end
      endcase
    end
  end

  // A beat whose owner has already dropped its request is never written.
  assign o_wr_en   = wr_en_q & req_n[owner_q];
  assign o_wr_data = o_wr_en ? data_n[owner_q] : '0;
  assign o_gnt     = gnt_q;
  assign o_owner   = owner_q;
  assign o_busy    = (state_q == ST_BURST) || (state_q == ST_GAP);

endmodule
